// File: rtl/control_unit.sv
// Multi-cycle control sequencer: fetch in T0-T2, opcode-specific execute in T3-T7.
// Optional macro CU_MUL_EN enables the mul sequence; without it opcode 01111 decodes as illegal.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        wren,
    output logic        Yin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        conInput,
    output logic        InPortout,
    output logic        outPortEnable,
    output logic [3:0]  ctrl,
    output logic        Run,
    output logic        Illegal
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110, OP_MUL  = 5'b01111, OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state_q, state_d;
    logic [4:0] opcode;
    logic       unused_ir;
    logic       is_r, is_i, is_ldi, is_ld, is_st, is_mul, is_br, is_halt, is_undef;
    logic [3:0] alu_op;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        is_r = 1'b0; is_i = 1'b0; is_ldi = 1'b0; is_ld = 1'b0; is_st = 1'b0;
        is_mul = 1'b0; is_br = 1'b0; is_halt = 1'b0; is_undef = 1'b0;
        alu_op = 4'd0;
        case (opcode)
            OP_ADD:  begin is_r = 1'b1; alu_op = 4'd0; end
            OP_SUB:  begin is_r = 1'b1; alu_op = 4'd1; end
            OP_AND:  begin is_r = 1'b1; alu_op = 4'd2; end
            OP_OR:   begin is_r = 1'b1; alu_op = 4'd3; end
            OP_ADDI: begin is_i = 1'b1; alu_op = 4'd0; end
            OP_ANDI: begin is_i = 1'b1; alu_op = 4'd2; end
            OP_ORI:  begin is_i = 1'b1; alu_op = 4'd3; end
            OP_LDI:  is_ldi = 1'b1;
            OP_LD:   is_ld = 1'b1;
            OP_ST:   is_st = 1'b1;
`ifdef CU_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`else
            OP_MUL:  is_undef = 1'b1;
`endif
            OP_BR:   is_br = 1'b1;
            OP_HALT: is_halt = 1'b1;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP: ;
            default: is_undef = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; wren = 1'b0; Yin = 1'b0;
        Zhighin = 1'b0; Zlowin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; conInput = 1'b0; InPortout = 1'b0;
        outPortEnable = 1'b0; ctrl = 4'd0; Illegal = 1'b0;
        Run = (state_q != S_IDLE) && (state_q != S_HALT);
        case (state_q)
            S_IDLE: state_d = S_T0;
            // Stop suppresses the fetch strobes so the PC is not advanced on the way into HALT
            S_T0: begin
                if (Stop) state_d = S_HALT;
                else begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                    state_d = S_T1;
                end
            end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; state_d = S_T2; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; state_d = S_T3; end
            S_T3: begin
                state_d = S_T4;
                if (is_r || is_i) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_mul) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; conInput = 1'b1;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_undef) begin
                    Illegal = 1'b1; state_d = S_T0;
                end else begin
                    state_d = S_T0;
                    case (opcode)
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortEnable = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                state_d = S_T5;
                if (is_r) begin
                    Grc = 1'b1; Rout = 1'b1; ctrl = alu_op; Zlowin = 1'b1;
                end else if (is_i) begin
                    Cout = 1'b1; ctrl = alu_op; Zlowin = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Cout = 1'b1; Zlowin = 1'b1;
                end else if (is_mul) begin
                    Grb = 1'b1; Rout = 1'b1; ctrl = 4'd4; Zhighin = 1'b1; Zlowin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T5: begin
                state_d = S_T6;
                if (is_r || is_i || is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_mul) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zlowin = 1'b1;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T6: begin
                state_d = S_T0;
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1; state_d = S_T7;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_T7;
                end else if (is_mul) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if (is_br && CON) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                state_d = S_T0;
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    wren = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: compares every output, packed into one vector, per T-state.
module tb_control_unit;
    logic        Clock, Clear, CON, Stop;
    logic [31:0] IR;
    logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, wren, Yin;
    logic Zhighin, Zlowin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, conInput, InPortout, outPortEnable;
    logic [3:0] ctrl;
    logic Run, Illegal;
    logic [33:0] obs;

    int errors = 0;
    int checks = 0;

    localparam logic [33:0] RUN = 34'd1 << 33, ILL = 34'd1 << 32;
    localparam logic [33:0] PCOUT = 34'd1 << 27, PCIN = 34'd1 << 26, INCPC = 34'd1 << 25;
    localparam logic [33:0] IRIN = 34'd1 << 24, MARIN = 34'd1 << 23, MDRIN = 34'd1 << 22;
    localparam logic [33:0] MDROUT = 34'd1 << 21, READ = 34'd1 << 20, WREN = 34'd1 << 19;
    localparam logic [33:0] YIN = 34'd1 << 18, ZHIGHIN = 34'd1 << 17, ZLOWIN = 34'd1 << 16;
    localparam logic [33:0] ZHIGHOUT = 34'd1 << 15, ZLOWOUT = 34'd1 << 14, HIIN = 34'd1 << 13;
    localparam logic [33:0] LOIN = 34'd1 << 11, GRA = 34'd1 << 9;
    localparam logic [33:0] GRB = 34'd1 << 8, GRC = 34'd1 << 7, RIN = 34'd1 << 6, ROUT = 34'd1 << 5;
    localparam logic [33:0] BAOUT = 34'd1 << 4, COUT = 34'd1 << 3, CONINPUT = 34'd1 << 2;
    localparam logic [33:0] C1 = 34'd1 << 28, C4 = 34'd4 << 28;
    localparam logic [33:0] F0 = RUN | PCOUT | MARIN | INCPC;
    localparam logic [33:0] F1 = RUN | READ | MDRIN;
    localparam logic [33:0] F2 = RUN | MDROUT | IRIN;

    assign obs = {Run, Illegal, ctrl, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, wren,
                  Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
                  Gra, Grb, Grc, Rin, Rout, BAout, Cout, conInput, InPortout, outPortEnable};

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .wren(wren), .Yin(Yin),
        .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .conInput(conInput), .InPortout(InPortout),
        .outPortEnable(outPortEnable), .ctrl(ctrl), .Run(Run), .Illegal(Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Clear = 1'b1; Stop = 1'b0; CON = 1'b0; IR = 32'h0;
        #2 Clear = 1'b0;
        tick(); tick();
        checks++;
        if (obs !== 34'd0) begin errors++; $display("FAIL reset_low: got %h want %h", obs, 34'd0); end
        Clear = 1'b1;
        #1;
        checks++;
        if (obs !== 34'd0) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, 34'd0); end
        tick();
        checks++;
        if (obs !== F0) begin errors++; $display("FAIL reset_t0: got %h want %h", obs, F0); end
    endtask

    task automatic test_alu();
        logic [33:0] e [7];
        IR = 32'h18918000;
        e = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZLOWIN, RUN|ZLOWOUT|GRA|RIN, F0};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL add_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 6) tick();
        end
        IR = 32'h20918000;
        e = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZLOWIN|C1, RUN|ZLOWOUT|GRA|RIN, F0};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL sub_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 6) tick();
        end
    endtask

    task automatic test_reset_mid();
        IR = 32'h18918000;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (obs !== (RUN|GRC|ROUT|ZLOWIN)) begin
            errors++; $display("FAIL mid_t4: got %h want %h", obs, RUN|GRC|ROUT|ZLOWIN);
        end
        #2 Clear = 1'b0;
        #1;
        checks++;
        if (obs !== 34'd0) begin errors++; $display("FAIL mid_clear: got %h want %h", obs, 34'd0); end
        Clear = 1'b1;
        tick();
        checks++;
        if (obs !== F0) begin errors++; $display("FAIL mid_restart: got %h want %h", obs, F0); end
    endtask

    task automatic test_mem();
        logic [33:0] e [9];
        IR = 32'h00000000;
        e = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZLOWIN, RUN|ZLOWOUT|MARIN,
              RUN|READ|MDRIN, RUN|MDROUT|GRA|RIN, F0};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL ld_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 8) tick();
        end
        IR = 32'h10800010;
        e = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZLOWIN, RUN|ZLOWOUT|MARIN,
              RUN|GRA|ROUT|MDRIN, RUN|WREN, F0};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL st_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 8) tick();
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (obs !== (RUN|WREN)) begin errors++; $display("FAIL st_t7: got %h want %h", obs, RUN|WREN); end
        #2 Clear = 1'b0;
        #1;
        checks++;
        if (obs !== 34'd0) begin errors++; $display("FAIL st_wren_drop: got %h want %h", obs, 34'd0); end
        Clear = 1'b1;
        tick();
        checks++;
        if (obs !== F0) begin errors++; $display("FAIL st_restart: got %h want %h", obs, F0); end
    endtask

    task automatic test_branch();
        logic [33:0] e [8];
        IR = 32'h90000000;
        for (int c = 0; c < 2; c++) begin
            CON = (c == 1);
            e = '{F0, F1, F2, RUN|GRA|ROUT|CONINPUT, RUN|PCOUT|YIN, RUN|COUT|ZLOWIN,
                  (c == 1) ? (RUN|ZLOWOUT|PCIN) : RUN, F0};
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs !== e[i]) begin
                    errors++; $display("FAIL br_con%0d_step%0d: got %h want %h", c, i, obs, e[i]);
                end
                if (i < 7) tick();
            end
        end
        CON = 1'b0;
    endtask

    task automatic test_single();
        logic [33:0] e [5];
        IR = 32'hA0000000;
        e = '{F0, F1, F2, RUN|GRA|ROUT|PCIN, F0};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL jr_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 4) tick();
        end
        IR = 32'hF8000000;
        e = '{F0, F1, F2, RUN|ILL, F0};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL illegal_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_mul();
`ifdef CU_MUL_EN
        logic [33:0] e [8];
        IR = 32'h78000000;
        e = '{F0, F1, F2, RUN|GRA|ROUT|YIN, RUN|GRB|ROUT|C4|ZHIGHIN|ZLOWIN,
              RUN|ZLOWOUT|LOIN, RUN|ZHIGHOUT|HIIN, F0};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL mul_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 7) tick();
        end
`else
        logic [33:0] e [5];
        IR = 32'h78000000;
        e = '{F0, F1, F2, RUN|ILL, F0};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL mul_undef_step%0d: got %h want %h", i, obs, e[i]); end
            if (i < 4) tick();
        end
`endif
    endtask

    task automatic test_halt();
        logic [33:0] e [4];
        IR = 32'hD8000000;
        e = '{F0, F1, F2, RUN};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL halt_step%0d: got %h want %h", i, obs, e[i]); end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs !== 34'd0) begin errors++; $display("FAIL halt_hold%0d: got %h want %h", i, obs, 34'd0); end
            tick();
        end
    endtask

    task automatic test_stop();
        IR = 32'h18918000;
        #2 Clear = 1'b0;
        #1 Clear = 1'b1;
        Stop = 1'b1;
        tick();
        checks++;
        if ((obs & ~(PCOUT|MARIN|INCPC)) !== RUN) begin
            errors++; $display("FAIL stop_t0: got %h want %h", obs & ~(PCOUT|MARIN|INCPC), RUN);
        end
        tick();
        checks++;
        if (obs !== 34'd0) begin errors++; $display("FAIL stop_halt: got %h want %h", obs, 34'd0); end
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 34'd0) begin errors++; $display("FAIL stop_hold%0d: got %h want %h", i, obs, 34'd0); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_reset_mid();
        test_mem();
        test_branch();
        test_single();
        test_mul();
        test_halt();
        test_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
